// File: rtl/usb_stream_in_ep_pkg.sv
// usb_stream_in_ep_pkg: shared endpoint FSM states and sizing helper
package usb_stream_in_ep_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, WAIT_ACK} ep_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo: synchronous FIFO with flush, first-word-fallthrough head
module usb_sync_fifo
  import usb_stream_in_ep_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/usb_stream_in_ep.sv
// usb_stream_in_ep: bulk IN endpoint packetising a byte stream for one PE IN slot
module usb_stream_in_ep
  import usb_stream_in_ep_pkg::*;
#(
  parameter int MAX_PACKET   = 64,
  parameter int FIFO_DEPTH   = 128,
  parameter int FLUSH_FRAMES = 1,
  parameter bit ZLP_EN       = 1'b1,
  parameter int HOST_TIMEOUT = 144000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         halt,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         sof_valid,
  output logic                         in_ep_req,
  input  logic                         in_ep_grant,
  input  logic                         in_ep_data_free,
  output logic                         in_ep_data_put,
  output logic [7:0]                   in_ep_data,
  output logic                         in_ep_data_done,
  output logic                         in_ep_stall,
  input  logic                         in_ep_acked,
  output logic                         host_present,
  output logic [clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = clog2(FIFO_DEPTH) + 1;
  localparam int PW = clog2(MAX_PACKET + 1);
  localparam int FW = clog2(FLUSH_FRAMES + 1);
  localparam int TW = clog2(HOST_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(HOST_TIMEOUT);
  ep_state_t state;
  logic [PW-1:0] pkt_len, sent;
  logic [FW-1:0] frame_age;
  logic [TW-1:0] host_timer;
  logic zlp_pending, full, empty, push, timeout, full_pkt, aged, start;
  assign in_ready = enable && host_present && !full;
  assign push = in_valid && in_ready;
  assign timeout = host_timer == TW'(HOST_TIMEOUT - 1) && !sof_valid;
  assign full_pkt = fifo_level >= LW'(MAX_PACKET);
  assign aged = frame_age == FW'(FLUSH_FRAMES);
  assign start = host_present && (full_pkt || (fifo_level != '0 && aged) ||
                 (ZLP_EN && zlp_pending && fifo_level == '0 && aged));
  assign in_ep_data_put = state == FILL && in_ep_grant && in_ep_data_free && !empty && sent < pkt_len;
  usb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (timeout),
    .push  (push),
    .din   (in_data),
    .pop   (in_ep_data_put),
    .dout  (in_ep_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ep_req <= 1'b0;
      in_ep_data_done <= 1'b0;
      in_ep_stall <= 1'b0;
      host_present <= 1'b0;
      host_timer <= '0;
      frame_age <= '0;
      zlp_pending <= 1'b0;
      pkt_len <= '0;
      sent <= '0;
    end else begin
      in_ep_stall <= halt;
      host_timer <= sof_valid ? '0 : host_timer + TW'(host_timer != TMAX);
      if (sof_valid) host_present <= 1'b1;
      else if (timeout) host_present <= 1'b0;
      frame_age <= (push || in_ep_acked) ? '0 : frame_age + FW'(sof_valid && !aged);
      // host loss abandons the packet in flight; the PE drops it on its side
      if (timeout) begin
        state <= IDLE;
        in_ep_req <= 1'b0;
        in_ep_data_done <= 1'b0;
        zlp_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= REQ;
            in_ep_req <= 1'b1;
            pkt_len <= full_pkt ? PW'(MAX_PACKET) : PW'(fifo_level);
            sent <= '0;
          end
          REQ: if (in_ep_grant) state <= FILL;
          FILL: if (sent == pkt_len) begin
            state <= WAIT_ACK;
            in_ep_req <= 1'b0;
            in_ep_data_done <= 1'b1;
          end else sent <= sent + PW'(in_ep_data_put);
          WAIT_ACK: if (in_ep_acked) begin
            state <= IDLE;
            in_ep_data_done <= 1'b0;
            zlp_pending <= pkt_len == PW'(MAX_PACKET);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_stream_in_ep.sv
// tb_usb_stream_in_ep: scoreboard bench for the stream IN endpoint
module tb_usb_stream_in_ep;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, halt = 1'b0;
  logic in_valid = 1'b0, sof_valid = 1'b0, in_ep_data_free = 1'b1, in_ep_acked = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, in_ep_req, in_ep_grant, in_ep_data_put, in_ep_data_done, in_ep_stall, host_present;
  logic [7:0] in_ep_data;
  logic [7:0] fifo_level;
  logic grant_en = 1'b0;
  int free_mode = 0, ack_delay = 2;
  int checks = 0, failures = 0, cur_len = 0, cyc = 0, sof_cyc = 0;
  logic [7:0] exp_bytes[$];
  int exp_lens[$];
  logic prev_done = 1'b0, prev_acked = 1'b0, prev_reset = 1'b1;

  assign in_ep_grant = in_ep_req & grant_en;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_stream_in_ep #(
    .MAX_PACKET(64), .FIFO_DEPTH(128), .FLUSH_FRAMES(1), .ZLP_EN(1'b1), .HOST_TIMEOUT(1000)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .halt(halt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sof_valid(sof_valid), .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
    .host_present(host_present), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not reached or unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    sof_valid = 1'b1;
    tick();
    sof_valid = 1'b0;
    sof_cyc = cyc;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      in_data = first + 8'(i);
      in_valid = 1'b1;
      while (!in_ready && w < 2000) begin
        tick();
        w++;
      end
      if (!in_ready) begin
        fail("push_timeout");
        break;
      end
      exp_bytes.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input string name);
    int w = 0;
    while ((exp_lens.size() > n || in_ep_data_done) && w < 1500) begin
      tick();
      w++;
    end
    if (exp_lens.size() > n || in_ep_data_done) fail(name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_req"}, in_ep_req, 0);
    chk({tag, "_put"}, in_ep_data_put, 0);
    chk({tag, "_done"}, in_ep_data_done, 0);
    chk({tag, "_host"}, host_present, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_stall"}, in_ep_stall, 0);
  endtask

  // PE model: free strobe pattern and delayed ack of completed packets
  initial begin
    int dcnt = 0;
    forever begin
      tick();
      in_ep_data_free = free_mode == 0 ? 1'b1 : free_mode == 1 ? ~in_ep_data_free : 1'b0;
      dcnt = in_ep_data_done ? dcnt + 1 : 0;
      in_ep_acked = ack_delay != 0 && dcnt == ack_delay;
    end
  end

  // monitor: compare each put byte and each completed packet length
  always @(negedge clk) begin
    if (!reset) begin
      if (in_ep_data_put) begin
        chk("put_when_free", in_ep_data_free, 1);
        if (exp_bytes.size() == 0) fail("unexpected_byte");
        else chk("data_byte", in_ep_data, exp_bytes.pop_front());
        cur_len++;
      end
      if (in_ep_data_done && !prev_done) begin
        if (exp_lens.size() == 0) fail("unexpected_packet");
        else chk("pkt_len", cur_len, exp_lens.pop_front());
        cur_len = 0;
      end
      if (prev_done && !prev_acked && !prev_reset) chk("done_held", in_ep_data_done, 1);
    end
    prev_done = in_ep_data_done;
    prev_acked = in_ep_acked;
    prev_reset = reset;
  end

  initial begin
    repeat (3) tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();
    chk("no_host_ready", in_ready, 0);
    // full packet, then ZLP after one idle SOF
    grant_en = 1'b1;
    ack_delay = 5;
    sof();
    chk("t1_host_up", host_present, 1);
    exp_lens.push_back(64);
    exp_lens.push_back(0);
    push_seq(8'h00, 64);
    wait_pkts(1, "t1_full_pkt");
    repeat (3) tick();
    chk("t1_zlp_waits_sof", in_ep_req, 0);
    sof();
    wait_pkts(0, "t1_zlp");
    // short packet flushed by SOF, no ZLP afterwards
    ack_delay = 2;
    exp_lens.push_back(5);
    push_seq(8'hA0, 5);
    repeat (8) tick();
    chk("t2_waits_sof", in_ep_req, 0);
    sof();
    wait_pkts(0, "t2_short");
    sof();
    repeat (6) tick();
    chk("t2_no_zlp", in_ep_req, 0);
    // overfill with no grant, then drain 64/64/2
    grant_en = 1'b0;
    sof();
    exp_lens.push_back(64);
    exp_lens.push_back(64);
    exp_lens.push_back(2);
    fork
      push_seq(8'h40, 130);
      begin
        int w = 0;
        while (fifo_level != 8'd128 && w < 400) begin
          tick();
          w++;
        end
        repeat (4) tick();
        chk("t3_level_cap", fifo_level, 128);
        chk("t3_ready_full", in_ready, 0);
        grant_en = 1'b1;
      end
    join
    wait_pkts(1, "t3_two_full");
    chk("t3_remainder", fifo_level, 2);
    sof();
    wait_pkts(0, "t3_tail");
    chk("t3_drained", fifo_level, 0);
    // throttled data_free
    free_mode = 1;
    sof();
    exp_lens.push_back(10);
    push_seq(8'hC0, 10);
    sof();
    wait_pkts(0, "t4_throttled");
    // host loss mid-FILL
    free_mode = 2;
    sof();
    exp_lens.push_back(64);
    push_seq(8'h80, 64);
    repeat (4) tick();
    chk("t5_in_fill_req", in_ep_req, 1);
    while (host_present && cyc - sof_cyc < 1100) tick();
    chk("t5_timeout_cycle", cyc - sof_cyc, 1000);
    chk("t5_level", fifo_level, 0);
    chk("t5_req", in_ep_req, 0);
    chk("t5_done", in_ep_data_done, 0);
    chk("t5_ready", in_ready, 0);
    exp_bytes.delete();
    exp_lens.delete();
    cur_len = 0;
    free_mode = 0;
    repeat (3) tick();
    sof();
    chk("t5_host_back", host_present, 1);
    // reset during WAIT_ACK, stall follows halt
    ack_delay = 0;
    exp_lens.push_back(3);
    push_seq(8'hE0, 3);
    sof();
    for (int i = 0; i < 200 && !in_ep_data_done; i++) tick();
    if (!in_ep_data_done) fail("t6_reach_wait_ack");
    halt = 1'b1;
    tick();
    chk("t6_stall", in_ep_stall, 1);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("t6");
    reset = 1'b0;
    halt = 1'b0;
    ack_delay = 2;
    tick();
    chk("leftover_bytes", exp_bytes.size(), 0);
    chk("leftover_pkts", exp_lens.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
